// File: rtl/joypad_poll_scheduler.sv
// joypad_poll_scheduler: SNES-style pad bus poller with valid/ready snapshot handoff; define JOYPAD_EDGE_EN to add the press_edge output
module joypad_poll_scheduler #(
    parameter int NUM_PORTS     = 2,
    parameter int HALF_PERIOD   = 6,
    parameter int LATCH_CYCLES  = 12,
    parameter int POLL_INTERVAL = 1400
) (
    input  logic                      clk,
    input  logic                      res_n,
    input  logic [NUM_PORTS-1:0]      data,
    input  logic                      poll_req,
    output logic                      latch,
    output logic                      clkout,
    output logic [16*NUM_PORTS-1:0]   pad_data,
    output logic                      valid,
    input  logic                      ready,
    output logic                      overrun,
`ifdef JOYPAD_EDGE_EN
    output logic                      busy,
    output logic [16*NUM_PORTS-1:0]   press_edge
`else
    output logic                      busy
`endif
);
    localparam int CW = $clog2(LATCH_CYCLES > HALF_PERIOD ? LATCH_CYCLES : HALF_PERIOD);
    localparam int TW = $clog2(POLL_INTERVAL);
    localparam logic [CW-1:0] LAT_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

    state_t                     state, state_nx;
    logic [CW-1:0]              cnt;
    logic [3:0]                 idx;
    logic [TW-1:0]              tmr;
    logic                       pending;
    logic [NUM_PORTS-1:0]       sync1, sync2;
    logic [15:0]                cap [NUM_PORTS];
    logic [16*NUM_PORTS-1:0]    cap_flat;
    logic                       timer_hit, start, accept, sample;

    assign timer_hit = tmr == TMR_LAST;
    assign start     = state == IDLE && (timer_hit || pending || poll_req);
    assign accept    = valid && ready;
    assign sample    = state == LOW && cnt == HP_LAST;
    assign latch     = state == LATCH;
    assign clkout    = state != LOW;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = LATCH;
            LATCH:   if (cnt == LAT_LAST) state_nx = LOW;
            LOW:     if (cnt == HP_LAST) state_nx = HIGH;
            HIGH:    if (cnt == HP_LAST) state_nx = idx == 4'd15 ? DONE : LOW;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            tmr     <= '0;
            pending <= 1'b0;
            sync1   <= '0;
            sync2   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= (state_nx != state || state == IDLE) ? '0 : cnt + 1'b1;
            idx     <= state == LATCH ? 4'd0 : (state == HIGH && cnt == HP_LAST) ? idx + 4'd1 : idx;
            // an expiry seen while busy is held so it fires on the next IDLE cycle
            tmr     <= start ? '0 : timer_hit ? tmr : tmr + 1'b1;
            pending <= !start && (pending || poll_req);
            sync1   <= data;
            sync2   <= sync1;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        always_ff @(posedge clk or negedge res_n) begin
            if (!res_n) cap[g] <= '0;
            else if (sample) cap[g][idx] <= ~sync2[g];
        end
        assign cap_flat[16*g +: 16] = cap[g];
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pad_data <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (state == DONE) pad_data <= cap_flat;
            valid   <= state == DONE || (valid && !ready);
            overrun <= (state == DONE && valid && !ready) || (overrun && !accept);
        end
    end

`ifdef JOYPAD_EDGE_EN
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) press_edge <= '0;
        else if (state == DONE) press_edge <= cap_flat & ~pad_data;
    end
`endif
endmodule

// File: tb/tb_joypad_poll_scheduler.sv
// tb_joypad_poll_scheduler: directed/randomized checks of the pad poller against a shift-register pad model
module tb_joypad_poll_scheduler;
    localparam int NP   = 2;
    localparam int HP   = 6;
    localparam int LC   = 12;
    localparam int PI   = 1400;
    localparam int POLL = LC + 32*HP;

    logic                 clk = 1'b0;
    logic                 res_n = 1'b0;
    logic                 poll_req = 1'b0;
    logic                 ready = 1'b0;
    logic [NP-1:0]        data;
    logic                 latch, clkout, valid, overrun, busy;
    logic [16*NP-1:0]     pad_data;
`ifdef JOYPAD_EDGE_EN
    logic [16*NP-1:0]     press_edge;
`endif

    int checks = 0;
    int failures = 0;
    int rises = 0;
    logic [15:0] raw [NP];
    logic [15:0] sh  [NP];

    joypad_poll_scheduler #(.NUM_PORTS(NP), .HALF_PERIOD(HP), .LATCH_CYCLES(LC), .POLL_INTERVAL(PI)) dut (
        .clk(clk), .res_n(res_n), .data(data), .poll_req(poll_req),
        .latch(latch), .clkout(clkout), .pad_data(pad_data), .valid(valid),
        .ready(ready), .overrun(overrun),
`ifdef JOYPAD_EDGE_EN
        .busy(busy), .press_edge(press_edge)
`else
        .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    // pad model: latch loads the raw buttons, each clkout rise shifts the next one out
    always @(posedge latch) begin
        rises++;
        for (int p = 0; p < NP; p++) sh[p] = raw[p];
    end
    always @(posedge clkout) begin
        if (!latch) for (int p = 0; p < NP; p++) sh[p] = {1'b1, sh[p][15:1]};
    end
    always @* begin
        for (int p = 0; p < NP; p++) data[p] = sh[p][0];
    end

    function automatic logic [16*NP-1:0] expect_snap();
        logic [16*NP-1:0] v;
        for (int p = 0; p < NP; p++) v[16*p +: 16] = ~raw[p];
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (busy !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) check({tag, "_timeout"}, 64'(busy), 64'(lvl));
    endtask

    task automatic req();
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
    endtask

    task automatic poll(input string tag);
        req();
        wait_busy(1'b0, tag);
    endtask

    task automatic randomize_raw();
        for (int p = 0; p < NP; p++) raw[p] = 16'($urandom);
    endtask

    task automatic accept_pulse(input string tag);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check({tag, "_valid_clear"}, 64'(valid), 64'(0));
        check({tag, "_overrun_clear"}, 64'(overrun), 64'(0));
    endtask

    initial begin
        int n, b, l, lo, r0;
        logic [16*NP-1:0] e1, e2, prev;
        for (int p = 0; p < NP; p++) begin
            sh[p]  = '1;
            raw[p] = '1;
        end
        tick(3);
        check("rst_latch", 64'(latch), 64'(0));
        check("rst_clkout", 64'(clkout), 64'(1));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_pad_data", 64'(pad_data), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));

        randomize_raw();
        res_n = 1'b1;
        n = 0;
        while (!latch && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("timer_first_latch", 64'(n), 64'(PI));
        b = 0; l = 0; lo = 0;
        while (busy && b < 1000) begin
            b++;
            if (latch) l++;
            if (!clkout) lo++;
            @(negedge clk);
        end
        check("poll_busy_cycles", 64'(b), 64'(POLL + 1));
        check("latch_cycles", 64'(l), 64'(LC));
        check("clkout_low_cycles", 64'(lo), 64'(16*HP));
        check("timer_valid", 64'(valid), 64'(1));
        check("timer_snapshot", 64'(pad_data), 64'(expect_snap()));
        check("timer_overrun", 64'(overrun), 64'(0));
        tick(20);
        check("timer_single_poll", 64'(rises), 64'(1));
        accept_pulse("s1");

        raw[0] = 16'hFFFE;
        raw[1] = 16'h7FFF;
        poll("capture");
        check("capture_pad_data", 64'(pad_data), 64'({16'h8000, 16'h0001}));
        check("capture_valid", 64'(valid), 64'(1));
        check("capture_overrun", 64'(overrun), 64'(0));
        accept_pulse("s2");

        randomize_raw();
        poll("bp_a");
        check("bp_a_snapshot", 64'(pad_data), 64'(expect_snap()));
        check("bp_a_overrun", 64'(overrun), 64'(0));
        for (int p = 0; p < NP; p++) raw[p] = raw[p] ^ 16'($urandom_range(1, 65535));
        poll("bp_b");
        check("bp_b_snapshot", 64'(pad_data), 64'(expect_snap()));
        check("bp_b_valid", 64'(valid), 64'(1));
        check("bp_b_overrun", 64'(overrun), 64'(1));
        e1 = expect_snap();
        tick(5);
        check("bp_hold", 64'(pad_data), 64'(e1));
        accept_pulse("s3");

        r0 = rises;
        randomize_raw();
        req();
        for (int k = 0; k < 3; k++) begin
            tick($urandom_range(5, 50));
            poll_req = 1'b1;
            tick(1);
            poll_req = 1'b0;
        end
        wait_busy(1'b0, "merge_first");
        e1 = expect_snap();
        check("merge_first_snapshot", 64'(pad_data), 64'(e1));
        randomize_raw();
        e2 = expect_snap();
        tick(1);
        check("merge_second_latch", 64'(latch), 64'(1));
        wait_busy(1'b0, "merge_second");
        tick(60);
        check("merge_poll_count", 64'(rises - r0), 64'(2));
        check("merge_second_snapshot", 64'(pad_data), 64'(e2));
        check("merge_overrun", 64'(overrun), 64'(1));
        accept_pulse("s4");

        randomize_raw();
        poll("acc_first");
        for (int p = 0; p < NP; p++) raw[p] = raw[p] ^ 16'($urandom_range(1, 65535));
        req();
        tick(POLL);
        check("acc_done_busy", 64'(busy), 64'(1));
        check("acc_done_valid", 64'(valid), 64'(1));
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("acc_same_cycle_valid", 64'(valid), 64'(1));
        check("acc_same_cycle_overrun", 64'(overrun), 64'(0));
        check("acc_same_cycle_snapshot", 64'(pad_data), 64'(expect_snap()));
        accept_pulse("s4b");

        randomize_raw();
        r0 = rises;
        req();
        tick(LC + 12*7 + 2);
        check("abort_bit7_low", 64'(clkout), 64'(0));
        #2 res_n = 1'b0;
        #1;
        check("abort_clkout", 64'(clkout), 64'(1));
        check("abort_latch", 64'(latch), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        @(negedge clk);
        res_n = 1'b1;
        tick(300);
        check("abort_valid", 64'(valid), 64'(0));
        check("abort_pad_data", 64'(pad_data), 64'(0));
        check("abort_no_repoll", 64'(rises - r0), 64'(1));

`ifdef JOYPAD_EDGE_EN
        prev = '0;
        for (int p = 0; p < NP; p++) raw[p] = ~(16'h1 << (p + 1));
        poll("edge_a");
        check("edge_a", 64'(press_edge), 64'(expect_snap() & ~prev));
        prev = expect_snap();
        for (int p = 0; p < NP; p++) raw[p] = raw[p] & ~(16'h1 << $urandom_range(8, 15));
        poll("edge_ab");
        check("edge_ab", 64'(press_edge), 64'(expect_snap() & ~prev));
        poll("edge_ab_again");
        check("edge_ab_again", 64'(press_edge), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
